// File: rtl/mem_io_sram_backend.sv
// mem_io_sram_backend: line-organised SRAM behind the tag cache MemIO port.
// Accepts one command at a time and absorbs a BEATS-beat write burst for a write.
// For a read it returns a BEATS-beat response burst after READ_LATENCY idle cycles.
// Every output is a register, loaded from the next-state decode.

module mem_io_sram_backend #(
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_WIDTH    = 5,
  parameter int DATA_WIDTH   = 128,
  parameter int BEATS        = 4,
  parameter int LINES_LOG2   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req_cmd_ready,
  input  logic                  mem_req_cmd_valid,
  input  logic [ADDR_WIDTH-1:0] mem_req_cmd_addr,
  input  logic [TAG_WIDTH-1:0]  mem_req_cmd_tag,
  input  logic                  mem_req_cmd_rw,
  output logic                  mem_req_data_ready,
  input  logic                  mem_req_data_valid,
  input  logic [DATA_WIDTH-1:0] mem_req_data_data,
  output logic                  mem_resp_valid,
  output logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [TAG_WIDTH-1:0]  mem_resp_tag
);

  localparam int BEAT_W   = $clog2(BEATS);
  localparam int IDX_W    = LINES_LOG2 + BEAT_W;
  localparam int DEPTH    = 1 << IDX_W;
  localparam int LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int LAT_LAST = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    RD_WAIT,
    RD_BEATS
  } state_t;

  state_t                  state_q, state_n;
  logic [LINES_LOG2-1:0]   line_q, line_n;
  logic [TAG_WIDTH-1:0]    tag_q, tag_n;
  logic [BEAT_W-1:0]       beat_q, beat_n;
  logic [LAT_W-1:0]        lat_q, lat_n;

  logic                    cmd_ready_q;
  logic                    data_ready_q;
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   resp_data_q;
  logic [TAG_WIDTH-1:0]    resp_tag_q;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  logic                    cmd_fire;
  logic                    data_fire;
  logic [IDX_W-1:0]        wr_idx;
  logic [IDX_W-1:0]        rd_idx;

  // Upper address bits only select an alias of the same physical line.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^mem_req_cmd_addr[ADDR_WIDTH-1:LINES_LOG2];

  assign cmd_fire  = mem_req_cmd_valid & cmd_ready_q;
  assign data_fire = mem_req_data_valid & data_ready_q;
  assign wr_idx    = {line_q, beat_q};
  assign rd_idx    = {line_n, beat_n};

  assign mem_req_cmd_ready  = cmd_ready_q;
  assign mem_req_data_ready = data_ready_q;
  assign mem_resp_valid     = resp_valid_q;
  assign mem_resp_data      = resp_data_q;
  assign mem_resp_tag       = resp_tag_q;

  // Next-state decode: command accept, write beat counting, read latency and read beat counting.
  always_comb begin
    state_n = state_q;
    line_n  = line_q;
    tag_n   = tag_q;
    beat_n  = beat_q;
    lat_n   = lat_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          line_n = mem_req_cmd_addr[LINES_LOG2-1:0];
          tag_n  = mem_req_cmd_tag;
          beat_n = '0;
          lat_n  = '0;
          if (mem_req_cmd_rw) begin
            state_n = WR_DATA;
          end else if (READ_LATENCY == 0) begin
            state_n = RD_BEATS;
          end else begin
            state_n = RD_WAIT;
          end
        end
      end
      WR_DATA: begin
        if (data_fire) begin
          if (beat_q == BEAT_LAST) begin
            state_n = IDLE;
            beat_n  = '0;
          end else begin
            beat_n = beat_q + BEAT_W'(1);
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == LAT_W'(LAT_LAST)) begin
          state_n = RD_BEATS;
          beat_n  = '0;
          lat_n   = '0;
        end else begin
          lat_n = lat_q + LAT_W'(1);
        end
      end
      RD_BEATS: begin
        if (beat_q == BEAT_LAST) begin
          state_n = IDLE;
          beat_n  = '0;
        end else begin
          beat_n = beat_q + BEAT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; the response beat is read as it is loaded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      line_q       <= '0;
      tag_q        <= '0;
      beat_q       <= '0;
      lat_q        <= '0;
      cmd_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_n;
      line_q       <= line_n;
      tag_q        <= tag_n;
      beat_q       <= beat_n;
      lat_q        <= lat_n;
      cmd_ready_q  <= (state_n == IDLE);
      data_ready_q <= (state_n == WR_DATA);
      resp_valid_q <= (state_n == RD_BEATS);
      if (state_n == RD_BEATS) begin
        resp_data_q <= mem[rd_idx];
        resp_tag_q  <= tag_n;
      end else begin
        resp_data_q <= '0;
      end
    end
  end

  // Line storage is never cleared, so a burst cut short by reset keeps the beats already written.
  always_ff @(posedge clk) begin
    if (data_fire) begin
      mem[wr_idx] <= mem_req_data_data;
    end
  end

endmodule

// File: tb/tb_mem_io_sram_backend.sv
// tb_mem_io_sram_backend: randomized and directed checks of mem_io_sram_backend
// against a transaction-level model of the line store and response schedule.

module tb_mem_io_sram_backend;

  localparam int L     = 2;
  localparam int BEATS = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mem_req_cmd_ready;
  logic         mem_req_cmd_valid = 1'b0;
  logic [25:0]  mem_req_cmd_addr = '0;
  logic [4:0]   mem_req_cmd_tag = '0;
  logic         mem_req_cmd_rw = 1'b0;
  logic         mem_req_data_ready;
  logic         mem_req_data_valid = 1'b0;
  logic [127:0] mem_req_data_data = '0;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [4:0]   mem_resp_tag;

  logic         z_cmd_ready;
  logic         z_cmd_valid = 1'b0;
  logic [25:0]  z_cmd_addr = '0;
  logic [4:0]   z_cmd_tag = '0;
  logic         z_cmd_rw = 1'b0;
  logic         z_data_ready;
  logic         z_data_valid = 1'b0;
  logic [127:0] z_data_data = '0;
  logic         z_resp_valid;
  logic [127:0] z_resp_data;
  logic [4:0]   z_resp_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] data;
    bit           known;
    logic [4:0]   tag;
  } beat_exp_t;

  logic [127:0] mem_model [int];
  beat_exp_t    resp_exp [int];
  bit           wr_active = 1'b0;
  int           wr_line = 0;
  int           wr_k = 0;
  int           ready_from = 0;

  logic [127:0] wr_beats [BEATS];
  logic [127:0] exp_beats [BEATS];

  mem_io_sram_backend #(.READ_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .mem_req_cmd_ready(mem_req_cmd_ready), .mem_req_cmd_valid(mem_req_cmd_valid),
    .mem_req_cmd_addr(mem_req_cmd_addr), .mem_req_cmd_tag(mem_req_cmd_tag),
    .mem_req_cmd_rw(mem_req_cmd_rw), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_data(mem_req_data_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_tag(mem_resp_tag)
  );

  mem_io_sram_backend #(.READ_LATENCY(0)) dut_lat0 (
    .clk(clk), .reset(reset),
    .mem_req_cmd_ready(z_cmd_ready), .mem_req_cmd_valid(z_cmd_valid),
    .mem_req_cmd_addr(z_cmd_addr), .mem_req_cmd_tag(z_cmd_tag),
    .mem_req_cmd_rw(z_cmd_rw), .mem_req_data_ready(z_data_ready),
    .mem_req_data_valid(z_data_valid), .mem_req_data_data(z_data_data),
    .mem_resp_valid(z_resp_valid), .mem_resp_data(z_resp_data),
    .mem_resp_tag(z_resp_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Transaction-level model: accepted commands schedule response beats and readiness by cycle number.
  always @(posedge clk) begin
    int c;
    bit rdy;
    beat_exp_t e;
    int line;
    c = cyc;
    if (!reset) begin
      wr_active = 1'b0;
      ready_from = 0;
      resp_exp.delete();
    end else begin
      rdy = !wr_active && (c >= ready_from);
      if (wr_active && mem_req_data_valid) begin
        mem_model[wr_line * BEATS + wr_k] = mem_req_data_data;
        wr_k++;
        if (wr_k == BEATS) begin
          wr_active = 1'b0;
          ready_from = c + 1;
        end
      end
      if (rdy && mem_req_cmd_valid) begin
        line = int'(mem_req_cmd_addr) % 1024;
        if (mem_req_cmd_rw) begin
          wr_active = 1'b1;
          wr_line = line;
          wr_k = 0;
        end else begin
          for (int b = 0; b < BEATS; b++) begin
            e.known = mem_model.exists(line * BEATS + b);
            e.data  = e.known ? mem_model[line * BEATS + b] : '0;
            e.tag   = mem_req_cmd_tag;
            resp_exp[c + L + 1 + b] = e;
          end
          ready_from = c + L + BEATS + 1;
        end
      end
    end
    cyc = c + 1;
  end

  // Every cycle compare the DUT outputs with what the model says this cycle must show.
  always @(negedge clk) begin
    bit has;
    if (!reset) begin
      check_output("rst_cmd_ready", mem_req_cmd_ready, 1);
      check_output("rst_data_ready", mem_req_data_ready, 0);
      check_output("rst_resp_valid", mem_resp_valid, 0);
      check_output("rst_resp_tag", mem_resp_tag, 0);
    end else begin
      has = resp_exp.exists(cyc);
      check_output("cmp_cmd_ready", mem_req_cmd_ready, !wr_active && (cyc >= ready_from));
      check_output("cmp_data_ready", mem_req_data_ready, wr_active);
      check_output("cmp_resp_valid", mem_resp_valid, has);
      if (has) begin
        check_output("cmp_resp_tag", mem_resp_tag, resp_exp[cyc].tag);
        if (resp_exp[cyc].known) check_output("cmp_resp_data", mem_resp_data, resp_exp[cyc].data);
      end
    end
  end

  task automatic wait_neg_cycle(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [25:0] a, input logic [4:0] t, input logic rw, input bit hold, output int acc_cyc);
    mem_req_cmd_valid = 1'b1;
    mem_req_cmd_addr = a;
    mem_req_cmd_tag = t;
    mem_req_cmd_rw = rw;
    acc_cyc = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (mem_req_cmd_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL cmd_accept_timeout: got no accept expected accept within 60 cycles");
      mem_req_cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) mem_req_cmd_valid = 1'b0;
    end
  endtask

  task automatic send_beats(input int gap, output int last_cyc);
    int k;
    bit v;
    bit took;
    k = 0;
    last_cyc = -1;
    for (int n = 0; n < 200 && k < BEATS; n++) begin
      v = (gap > 0) ? (n % gap == 0) : ($urandom % 3 != 0);
      mem_req_data_valid = v;
      mem_req_data_data = v ? wr_beats[k] : {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      took = v && mem_req_data_ready;
      if (took && k == BEATS - 1) last_cyc = cyc;
      @(posedge clk);
      #1;
      if (took) k++;
    end
    mem_req_data_valid = 1'b0;
    if (k < BEATS) begin
      checks++;
      failures++;
      $display("[TB] FAIL write_beats_timeout: got %0d beats expected %0d", k, BEATS);
    end
  endtask

  task automatic write_line(input logic [25:0] a, input logic [4:0] t, input int gap, output int last_cyc);
    int acc;
    last_cyc = -1;
    send_cmd(a, t, 1'b1, 1'b0, acc);
    if (acc >= 0) send_beats(gap, last_cyc);
  endtask

  task automatic read_and_check(input logic [25:0] a, input logic [4:0] t, input string name);
    int tt;
    send_cmd(a, t, 1'b0, 1'b0, tt);
    if (tt < 0) return;
    wait_neg_cycle(tt + L);
    check_output({name, "_pre_valid"}, mem_resp_valid, 0);
    for (int b = 0; b < BEATS; b++) begin
      wait_neg_cycle(tt + L + 1 + b);
      check_output($sformatf("%s_beat%0d_valid", name, b), mem_resp_valid, 1);
      check_output($sformatf("%s_beat%0d_data", name, b), mem_resp_data, exp_beats[b]);
      check_output($sformatf("%s_beat%0d_tag", name, b), mem_resp_tag, t);
    end
    wait_neg_cycle(tt + L + BEATS + 1);
    check_output({name, "_post_valid"}, mem_resp_valid, 0);
    check_output({name, "_post_cmd_ready"}, mem_req_cmd_ready, 1);
  endtask

  task automatic run_lat0_build();
    z_cmd_valid = 1'b1; z_cmd_rw = 1'b1; z_cmd_addr = 26'h22; z_cmd_tag = 5'd0;
    @(negedge clk);
    check_output("lat0_wr_cmd_ready", z_cmd_ready, 1);
    @(posedge clk); #1;
    z_cmd_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      z_data_valid = 1'b1;
      z_data_data = 128'hB0 + 128'(b);
      @(negedge clk);
      check_output("lat0_data_ready", z_data_ready, 1);
      @(posedge clk); #1;
    end
    z_data_valid = 1'b0;
    @(negedge clk);
    check_output("lat0_wr_done_cmd_ready", z_cmd_ready, 1);
    z_cmd_valid = 1'b1; z_cmd_rw = 1'b0; z_cmd_tag = 5'd9;
    @(posedge clk); #1;
    z_cmd_valid = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      @(negedge clk);
      check_output("lat0_resp_valid", z_resp_valid, 1);
      check_output("lat0_resp_data", z_resp_data, 128'hB0 + 128'(b));
      check_output("lat0_resp_tag", z_resp_tag, 5'd9);
    end
    @(negedge clk);
    check_output("lat0_post_valid", z_resp_valid, 0);
    check_output("lat0_post_cmd_ready", z_cmd_ready, 1);
  endtask

  task automatic apply_stimulus();
    int t;
    int w;
    logic [9:0]  line;
    logic [15:0] hi;
    // Directed: write then read back one line.
    for (int b = 0; b < BEATS; b++) wr_beats[b] = 128'hA0 + 128'(b);
    write_line(26'h10, 5'd3, 1, w);
    send_cmd(26'h10, 5'd7, 1'b0, 1'b0, t);
    wait_neg_cycle(t + 2);
    check_output("t2_valid_T2", mem_resp_valid, 0);
    for (int b = 0; b < BEATS; b++) begin
      wait_neg_cycle(t + 3 + b);
      check_output("t2_valid", mem_resp_valid, 1);
      check_output("t2_data", mem_resp_data, 128'hA0 + 128'(b));
      check_output("t2_tag", mem_resp_tag, 5'd7);
    end
    wait_neg_cycle(t + 7);
    check_output("t2_cmd_ready_T7", mem_req_cmd_ready, 1);
    // Write with a beat every third cycle.
    @(posedge clk); #1;
    for (int b = 0; b < BEATS; b++) wr_beats[b] = 128'hC0 + 128'(b);
    write_line(26'h20, 5'd1, 3, w);
    wait_neg_cycle(w + 1);
    check_output("t3_cmd_ready_after_last", mem_req_cmd_ready, 1);
    for (int b = 0; b < BEATS; b++) exp_beats[b] = 128'hC0 + 128'(b);
    read_and_check(26'h20, 5'd2, "t3_read");
    // Aliasing modulo 1024 lines.
    @(posedge clk); #1;
    for (int b = 0; b < BEATS; b++) wr_beats[b] = 128'h50 + 128'(b);
    write_line(26'h005, 5'd4, 0, w);
    for (int b = 0; b < BEATS; b++) exp_beats[b] = 128'h50 + 128'(b);
    read_and_check(26'h405, 5'd5, "t4_alias");
    // Stray data in idle, command held through a read burst.
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      mem_req_data_valid = 1'b1;
      mem_req_data_data = 128'hDEAD;
      @(negedge clk);
      check_output("t5_idle_data_ready", mem_req_data_ready, 0);
      @(posedge clk); #1;
    end
    mem_req_data_valid = 1'b0;
    send_cmd(26'h10, 5'd4, 1'b0, 1'b1, t);
    for (int k = 1; k <= 6; k++) begin
      mem_req_data_valid = (k % 2 == 1);
      mem_req_data_data = 128'hBEEF;
      wait_neg_cycle(t + k);
      check_output("t5_burst_cmd_ready", mem_req_cmd_ready, 0);
      check_output("t5_burst_data_ready", mem_req_data_ready, 0);
      @(posedge clk); #1;
    end
    mem_req_data_valid = 1'b0;
    wait_neg_cycle(t + 7);
    check_output("t5_cmd_ready_T7", mem_req_cmd_ready, 1);
    @(posedge clk); #1;
    mem_req_cmd_valid = 1'b0;
    wait_neg_cycle(t + 10);
    check_output("t5_second_valid", mem_resp_valid, 1);
    check_output("t5_second_data", mem_resp_data, 128'hA0);
    wait_neg_cycle(t + 14);
    check_output("t5_second_done", mem_req_cmd_ready, 1);
    // Reset in the middle of a read burst.
    @(posedge clk); #1;
    send_cmd(26'h10, 5'd1, 1'b0, 1'b0, t);
    wait_neg_cycle(t + 4);
    check_output("t6_beat1_data", mem_resp_data, 128'hA1);
    #2 reset = 1'b0;
    #1;
    check_output("t6_async_valid", mem_resp_valid, 0);
    check_output("t6_async_cmd_ready", mem_req_cmd_ready, 1);
    check_output("t6_async_data_ready", mem_req_data_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int b = 0; b < BEATS; b++) exp_beats[b] = 128'hA0 + 128'(b);
    read_and_check(26'h10, 5'd2, "t6_after_reset");
    // Random traffic over a small pool of lines with random upper address bits.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        mem_req_data_valid = $urandom % 2;
        mem_req_data_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
      end
      mem_req_data_valid = 1'b0;
      line = 10'h040 + 10'($urandom_range(0, 7));
      hi = 16'($urandom);
      if ($urandom % 2 == 1) begin
        for (int b = 0; b < BEATS; b++) wr_beats[b] = {$urandom, $urandom, $urandom, $urandom};
        write_line({hi, line}, 5'($urandom), 0, w);
      end else begin
        send_cmd({hi, line}, 5'($urandom), 1'b0, 1'b0, t);
      end
    end
    repeat (L + BEATS + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("t1_in_reset_cmd_ready", mem_req_cmd_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_output("t1_cmd_ready", mem_req_cmd_ready, 1);
    check_output("t1_data_ready", mem_req_data_ready, 0);
    check_output("t1_resp_valid", mem_resp_valid, 0);
    check_output("t1_resp_tag", mem_resp_tag, 0);
    @(posedge clk); #1;
    run_lat0_build();
    @(posedge clk); #1;
    apply_stimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
